// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: architectural register numbers and the
// writeback-stage run/halt state encoding.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_32x32.sv
// 32 x DATA_W architectural register file: one synchronous write port,
// two combinational read ports with write-through bypass, $v0/$a0 taps.
module regfile_32x32
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        ra_no,
  input  logic [4:0]        rb_no,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] v0_data,
  output logic [DATA_W-1:0] a0_data
);

  logic [DATA_W-1:0] regs [32];

  // $0 is never written, so regs[0] stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != REG_ZERO) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    if (ra_no == REG_ZERO)              ra_data = '0;
    else if (we && ra_no == waddr)      ra_data = wdata;
    else                                ra_data = regs[ra_no];
  end

  always_comb begin
    if (rb_no == REG_ZERO)              rb_data = '0;
    else if (we && rb_no == waddr)      rb_data = wdata;
    else                                rb_data = regs[rb_no];
  end

  // Syscall operands come straight from the array; a syscall never writes.
  assign v0_data = regs[REG_V0];
  assign a0_data = regs[REG_A0];

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects and commits the writeback value, serves the ID
// read ports, executes print/exit syscalls and counts retired instructions.
module wb_regfile_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 32,
  parameter int EXIT_CODE = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              effective,
  input  logic [31:0]       ir,
  input  logic [31:0]       pc,
  input  logic              syscall,
  input  logic              jal,
  input  logic              reg_write,
  input  logic              write_back,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [4:0]        rd_no,
  input  logic [4:0]        ra_no,
  input  logic [4:0]        rb_no,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              halt,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic [CNT_W-1:0]  retire_cnt
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] wdata, v0_data, a0_data;
  logic [4:0]        wdest;
  logic              we, retire, sys_fire, v0_exit;
  logic              unused_ir;

  assign unused_ir = ^ir;

  assign wdata    = jal ? DATA_W'(pc + 32'd4) : (write_back ? r2 : r1);
  assign wdest    = jal ? REG_RA : rd_no;
  assign retire   = (state_q == RUN) && effective;
  assign we       = retire && (reg_write || jal) && (wdest != REG_ZERO);
  assign sys_fire = retire && syscall;
  assign v0_exit  = (v0_data == DATA_W'(EXIT_CODE));

  regfile_32x32 #(.DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (wdest),
    .wdata   (wdata),
    .ra_no   (ra_no),
    .rb_no   (rb_no),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .v0_data (v0_data),
    .a0_data (a0_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (sys_fire && v0_exit) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halt = (state_q == HALTED);
  end

  // disp_valid is a one-cycle strobe with no ready: the consumer must take
  // disp_data in the cycle disp_valid is high; disp_data holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (sys_fire && !v0_exit) begin
        disp_data  <= a0_data;
        disp_valid <= 1'b1;
      end
    end
  end

  // Saturates rather than wrapping so a long run never reads as a short one.
  always_ff @(posedge clk) begin
    if (rst)                          retire_cnt <= '0;
    else if (retire && retire_cnt != '1) retire_cnt <= retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: register/halt/counter checks inline,
// printed values checked by a scoreboard monitor on disp_valid.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        effective, syscall, jal, reg_write, write_back;
  logic [31:0] ir, pc, r1, r2;
  logic [4:0]  rd_no, ra_no, rb_no;
  logic [31:0] ra_data, rb_data, disp_data, retire_cnt;
  logic        halt, disp_valid;
  logic [31:0] ra_data4, rb_data4, disp_data4;
  logic        halt4, disp_valid4;
  logic [3:0]  retire_cnt4;

  logic [31:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .rst(rst), .effective(effective), .ir(ir), .pc(pc),
    .syscall(syscall), .jal(jal), .reg_write(reg_write), .write_back(write_back),
    .r1(r1), .r2(r2), .rd_no(rd_no), .ra_no(ra_no), .rb_no(rb_no),
    .ra_data(ra_data), .rb_data(rb_data), .halt(halt),
    .disp_data(disp_data), .disp_valid(disp_valid), .retire_cnt(retire_cnt)
  );

  wb_regfile_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .effective(effective), .ir(ir), .pc(pc),
    .syscall(syscall), .jal(jal), .reg_write(reg_write), .write_back(write_back),
    .r1(r1), .r2(r2), .rd_no(rd_no), .ra_no(ra_no), .rb_no(rb_no),
    .ra_data(ra_data4), .rb_data(rb_data4), .halt(halt4),
    .disp_data(disp_data4), .disp_valid(disp_valid4), .retire_cnt(retire_cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    effective = 0; syscall = 0; jal = 0; reg_write = 0; write_back = 0;
    r1 = '0; r2 = '0; pc = '0; rd_no = '0; ir = '0;
  endtask

  task automatic issue(input logic eff, input logic sc, input logic j, input logic rw,
                       input logic wb, input logic [31:0] r1v, input logic [31:0] r2v,
                       input logic [31:0] pcv, input logic [4:0] rd);
    effective = eff; syscall = sc; jal = j; reg_write = rw; write_back = wb;
    r1 = r1v; r2 = r2v; pc = pcv; rd_no = rd; ir = $urandom;
    tick();
    idle();
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] val);
    issue(1, 0, 0, 1, 0, val, 32'h0, 32'h0, rd);
  endtask

  task automatic read_reg(input string name, input logic [4:0] n, input logic [31:0] exp);
    ra_no = n; rb_no = n;
    #1;
    check({name, " ra"}, ra_data, exp);
    check({name, " rb"}, rb_data, exp);
  endtask

  // Scoreboard monitor: every disp_valid strobe must match the oldest print queued.
  always @(negedge clk) begin
    if (disp_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL disp_unexpected: got 0x%08h expected no strobe", disp_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (disp_data !== e) begin
          n_miss++;
          $display("FAIL disp_data: got 0x%08h expected 0x%08h", disp_data, e);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    ra_no = 0; rb_no = 0;
    rst = 1;
    tick(); tick();
    rst = 0;

    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_disp_valid", {31'b0, disp_valid}, 32'h0);
    check("rst_disp_data", disp_data, 32'h0);
    check("rst_cnt", retire_cnt, 32'h0);
    read_reg("rst_r8", 5'd8, 32'h0);

    // ALU writeback with same-cycle bypass on port A; port B misses the bypass.
    effective = 1; reg_write = 1; rd_no = 5'd8; r1 = 32'h1234;
    ra_no = 5'd8; rb_no = 5'd9;
    #1;
    check("bypass_ra", ra_data, 32'h1234);
    check("bypass_rb_other", rb_data, 32'h0);
    tick();
    idle();
    check("cnt_1", retire_cnt, 32'd1);
    read_reg("r8", 5'd8, 32'h1234);

    issue(1, 0, 1, 0, 0, 32'h5, 32'h6, 32'h0040_0010, 5'd5);
    read_reg("jal_r31", 5'd31, 32'h0040_0014);
    read_reg("jal_r5_untouched", 5'd5, 32'h0);
    wr(5'd0, 32'hFFFF);
    read_reg("r0_zero", 5'd0, 32'h0);
    issue(1, 0, 0, 1, 1, 32'h1, 32'hDEAD, 32'h0, 5'd9);
    read_reg("load_r9", 5'd9, 32'hDEAD);
    check("cnt_4", retire_cnt, 32'd4);

    wr(5'd2, 32'd10);
    wr(5'd4, 32'hCAFE);
    // Bubble carrying a halting syscall and a write must do nothing.
    issue(0, 1, 0, 1, 0, 32'h77, 32'h0, 32'h0, 5'd7);
    tick();
    check("bubble_halt", {31'b0, halt}, 32'h0);
    check("bubble_cnt", retire_cnt, 32'd6);
    read_reg("bubble_r7", 5'd7, 32'h0);

    wr(5'd2, 32'd1);
    exp_q.push_back(32'hCAFE);
    issue(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    check("print_halt", {31'b0, halt}, 32'h0);
    wr(5'd4, 32'h55AA);
    exp_q.push_back(32'h55AA);
    issue(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    check("print_cnt", retire_cnt, 32'd10);

    wr(5'd2, 32'd10);
    issue(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    check("exit_halt", {31'b0, halt}, 32'h1);
    check("exit_cnt", retire_cnt, 32'd12);
    check("exit_disp_kept", disp_data, 32'h55AA);
    wr(5'd9, 32'h999);
    issue(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    read_reg("halted_r9", 5'd9, 32'hDEAD);
    check("halted_cnt", retire_cnt, 32'd12);
    check("halted_sticky", {31'b0, halt}, 32'h1);

    // Reset while halted, with a write presented in the same cycle.
    rst = 1;
    issue(1, 0, 0, 1, 0, 32'h4444, 32'h0, 32'h0, 5'd8);
    rst = 0;
    check("rst2_halt", {31'b0, halt}, 32'h0);
    check("rst2_cnt", retire_cnt, 32'h0);
    check("rst2_cnt4", {28'b0, retire_cnt4}, 32'h0);
    read_reg("rst2_r8", 5'd8, 32'h0);
    read_reg("rst2_r31", 5'd31, 32'h0);
    read_reg("rst2_r9", 5'd9, 32'h0);

    for (int i = 0; i < 17; i++) issue(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    check("sat_cnt32", retire_cnt, 32'd17);
    check("sat_cnt4", {28'b0, retire_cnt4}, 32'd15);

    // Halting syscall coinciding with reset: reset wins.
    wr(5'd2, 32'd10);
    rst = 1;
    issue(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    rst = 0;
    check("rst_vs_exit_halt", {31'b0, halt}, 32'h0);
    check("rst_vs_exit_cnt", retire_cnt, 32'h0);

    tick(); tick();
    check("disp_queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
